// File: rtl/data_mem_port.sv
// data_mem_port: turns decoder load/store controls into a registered, handshaked
// word-wide SRAM access with byte-lane enables, and stalls the core until the
// access completes. Load data is lane-extracted and sign/zero extended.
module data_mem_port #(
   parameter int ADDR_W  = 10,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              re_in,
   input  logic              we_in,
   input  logic [1:0]        size_in,
   input  logic              signed_in,
   input  logic [31:0]       addr_in,
   input  logic [31:0]       wdata_in,
   output logic [31:0]       rdata_out,
   output logic              stall_out,
   output logic              err_out,
   output logic              mem_req_out,
   output logic              mem_we_out,
   output logic [ADDR_W-1:0] mem_addr_out,
   output logic [3:0]        mem_be_out,
   output logic [31:0]       mem_wdata_out,
   input  logic              mem_ack_in,
   input  logic [31:0]       mem_rdata_in
);
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [1:0]       r_size;
   logic [1:0]       r_lane;
   logic             r_signed;

   logic [1:0]       w_lane;
   logic             w_req;
   logic             w_illegal;
   logic [3:0]       w_be;
   logic [31:0]      w_wdata;
   logic [7:0]       w_byte;
   logic [15:0]      w_half;
   logic [31:0]      w_load;
   logic [CNT_W-1:0] w_cnt_inc;
   logic             w_unused_addr;

   assign w_lane        = addr_in[1:0];
   assign w_req         = re_in | we_in;
   assign w_cnt_inc     = r_cnt + 1'b1;
   // Upper address bits lie beyond the SRAM and are deliberately dropped.
   assign w_unused_addr = ^addr_in[31:ADDR_W+2];

   // Core is held while a request waits in IDLE or an access is in flight.
   assign stall_out = reset_n & (((r_state == S_IDLE) & w_req) | (r_state == S_REQ));

   // Classify the request: conflicting enables, reserved size, misalignment.
   always_comb begin
      w_illegal = re_in & we_in;
      case (size_in)
         2'b10:   w_illegal = 1'b1;
         2'b01:   if (addr_in[0]) w_illegal = 1'b1;
         2'b11:   if (|addr_in[1:0]) w_illegal = 1'b1;
         default: ;
      endcase
   end

   // Byte-lane enables and lane-replicated store data for the request.
   always_comb begin
      w_be    = 4'b1111;
      w_wdata = wdata_in;
      case (size_in)
         2'b00: begin
            w_be    = 4'b0001 << w_lane;
            w_wdata = {4{wdata_in[7:0]}};
         end
         2'b01: begin
            w_be    = w_lane[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{wdata_in[15:0]}};
         end
         default: ;
      endcase
   end

   // Extract the addressed lane(s) of the returned word and extend them.
   always_comb begin
      w_byte = mem_rdata_in[7:0];
      case (r_lane)
         2'd1:    w_byte = mem_rdata_in[15:8];
         2'd2:    w_byte = mem_rdata_in[23:16];
         2'd3:    w_byte = mem_rdata_in[31:24];
         default: ;
      endcase
      w_half = r_lane[1] ? mem_rdata_in[31:16] : mem_rdata_in[15:0];
      case (r_size)
         2'b00:   w_load = {{24{r_signed & w_byte[7]}}, w_byte};
         2'b01:   w_load = {{16{r_signed & w_half[15]}}, w_half};
         default: w_load = mem_rdata_in;
      endcase
   end

   // Access sequencer: IDLE accepts, REQ waits for ack or timeout, DONE releases the core.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state       <= S_IDLE;
         r_cnt         <= '0;
         r_size        <= 2'b00;
         r_lane        <= 2'b00;
         r_signed      <= 1'b0;
         rdata_out     <= 32'd0;
         err_out       <= 1'b0;
         mem_req_out   <= 1'b0;
         mem_we_out    <= 1'b0;
         mem_addr_out  <= '0;
         mem_be_out    <= 4'b0000;
         mem_wdata_out <= 32'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_req) begin
                  if (w_illegal) begin
                     err_out   <= 1'b1;
                     rdata_out <= 32'd0;
                     r_state   <= S_DONE;
                  end else begin
                     mem_req_out   <= 1'b1;
                     mem_we_out    <= we_in;
                     mem_addr_out  <= addr_in[ADDR_W+1:2];
                     mem_be_out    <= w_be;
                     mem_wdata_out <= w_wdata;
                     r_size        <= size_in;
                     r_lane        <= w_lane;
                     r_signed      <= signed_in;
                     r_cnt         <= '0;
                     r_state       <= S_REQ;
                  end
               end
            end
            S_REQ: begin
               if (mem_ack_in) begin
                  // An ack arriving on the last allowed cycle still completes normally.
                  mem_req_out <= 1'b0;
                  mem_we_out  <= 1'b0;
                  rdata_out   <= mem_we_out ? 32'd0 : w_load;
                  err_out     <= 1'b0;
                  r_state     <= S_DONE;
               end else begin
                  r_cnt <= w_cnt_inc;
                  if (w_cnt_inc == CNT_W'(TIMEOUT)) begin
                     mem_req_out <= 1'b0;
                     mem_we_out  <= 1'b0;
                     rdata_out   <= 32'd0;
                     err_out     <= 1'b1;
                     r_state     <= S_DONE;
                  end
               end
            end
            S_DONE: begin
               // Any request seen here belongs to the completing instruction.
               err_out <= 1'b0;
               r_cnt   <= '0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_data_mem_port.sv
// tb_data_mem_port: table-driven directed vectors, hand-written reset/timing
// sequences and randomized transactions checked against a byte-level model.
module tb_data_mem_port;
   localparam int ADDR_W  = 10;
   localparam int TIMEOUT = 15;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        re_in = 1'b0;
   logic        we_in = 1'b0;
   logic [1:0]  size_in = 2'b00;
   logic        signed_in = 1'b0;
   logic [31:0] addr_in = 32'd0;
   logic [31:0] wdata_in = 32'd0;
   logic [31:0] rdata_out;
   logic        stall_out;
   logic        err_out;
   logic        mem_req_out;
   logic        mem_we_out;
   logic [ADDR_W-1:0] mem_addr_out;
   logic [3:0]  mem_be_out;
   logic [31:0] mem_wdata_out;
   logic        mem_ack_in = 1'b0;
   logic [31:0] mem_rdata_in = 32'd0;

   always #5 clk = ~clk;

   data_mem_port #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset_n(reset_n), .re_in(re_in), .we_in(we_in),
      .size_in(size_in), .signed_in(signed_in), .addr_in(addr_in),
      .wdata_in(wdata_in), .rdata_out(rdata_out), .stall_out(stall_out),
      .err_out(err_out), .mem_req_out(mem_req_out), .mem_we_out(mem_we_out),
      .mem_addr_out(mem_addr_out), .mem_be_out(mem_be_out),
      .mem_wdata_out(mem_wdata_out), .mem_ack_in(mem_ack_in),
      .mem_rdata_in(mem_rdata_in)
   );

   logic [31:0] sram    [0:1023];
   logic [31:0] ref_mem [0:1023];
   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      int          stall;
      int          reqc;
      logic [31:0] rdata;
      logic        err;
      logic [3:0]  be;
      logic [9:0]  maddr;
      logic [31:0] mwdata;
      logic        mwe;
      logic        req_after;
      logic        timed_out;
   } obs_t;

   typedef struct {
      logic        re, we;
      logic [1:0]  sz;
      logic        sg;
      logic [31:0] addr, wdata;
      int          delay;
      logic [31:0] x_rdata;
      logic        x_err;
      int          x_stall;
      logic [3:0]  x_be;
      logic [9:0]  x_maddr;
      logic [31:0] x_mwdata;
   } vec_t;

   typedef struct {
      int          stall;
      logic [31:0] rdata;
      logic        err;
      logic        legal;
      logic [3:0]  be;
      logic [9:0]  maddr;
      logic [31:0] mwdata;
   } exp_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
      end
   endtask

   // Runs one instruction starting just after a falling edge; SRAM acks on the delay-th REQ cycle (0 = never).
   task automatic run_access(input logic re, input logic we, input logic [1:0] sz, input logic sg,
                             input logic [31:0] a, input logic [31:0] wd, input int delay, output obs_t o);
      bit done = 0;
      o.stall = 0; o.reqc = 0; o.rdata = 0; o.err = 0; o.be = 0; o.maddr = 0;
      o.mwdata = 0; o.mwe = 0; o.req_after = 0; o.timed_out = 0;
      re_in = re; we_in = we; size_in = sz; signed_in = sg; addr_in = a; wdata_in = wd;
      for (int c = 0; c < 40; c++) begin
         mem_ack_in = 1'b0;
         #1;
         if (!stall_out) begin
            done = 1;
            break;
         end
         o.stall++;
         if (mem_req_out) begin
            o.reqc++;
            if (o.reqc == 1) begin
               o.be = mem_be_out; o.maddr = mem_addr_out; o.mwdata = mem_wdata_out; o.mwe = mem_we_out;
            end
            if (o.reqc == delay) begin
               mem_ack_in   = 1'b1;
               mem_rdata_in = sram[mem_addr_out];
               if (mem_we_out)
                  for (int b = 0; b < 4; b++)
                     if (mem_be_out[b]) sram[mem_addr_out][8*b +: 8] = mem_wdata_out[8*b +: 8];
            end
         end
         @(negedge clk);
      end
      mem_ack_in = 1'b0;
      if (!done) begin
         o.timed_out = 1;
         n_cmp++; n_bad++;
         $display("FAIL stall_bound: stall_out still high after 40 cycles, required low");
      end
      o.rdata = rdata_out;
      o.err   = err_out;
      // Hold the old request across the DONE edge: it must not start a second access.
      @(negedge clk);
      #1;
      o.req_after = mem_req_out;
      re_in = 1'b0; we_in = 1'b0;
   endtask

   // Reference: byte-addressed little-endian memory with alignment rules and handshake latency.
   task automatic model(input logic re, input logic we, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd, input int delay, output exp_t e);
      int nb, lane;
      logic [31:0] w, mask;
      lane = int'(a % 4);
      nb = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
      e.legal = !(re && we) && (sz != 2'b10) && (lane % nb == 0);
      e.maddr = a[ADDR_W+1:2];
      e.be = 4'(((1 << nb) - 1) << lane);
      e.mwdata = 0;
      for (int i = 0; i < 4; i++) e.mwdata[8*i +: 8] = wd[8*(i % nb) +: 8];
      if (!e.legal) begin
         e.stall = 1; e.err = 1; e.rdata = 0;
      end else if (delay < 1 || delay > TIMEOUT) begin
         e.stall = TIMEOUT + 1; e.err = 1; e.rdata = 0;
      end else begin
         e.stall = delay + 1; e.err = 0;
         if (we) begin
            e.rdata = 0;
            for (int i = 0; i < nb; i++) ref_mem[e.maddr][8*(lane+i) +: 8] = wd[8*i +: 8];
         end else begin
            w = ref_mem[e.maddr] >> (8 * lane);
            if (nb < 4) begin
               mask = (32'd1 << (8 * nb)) - 32'd1;
               w = w & mask;
               if (sg && w[8*nb-1]) w = w | ~mask;
            end
            e.rdata = w;
         end
      end
   endtask

   function automatic vec_t mk(input logic re, input logic we, input logic [1:0] sz, input logic sg,
                               input logic [31:0] a, input logic [31:0] wd, input int d,
                               input logic [31:0] xr, input logic xe, input int xs,
                               input logic [3:0] xbe, input logic [9:0] xma, input logic [31:0] xwd);
      vec_t v;
      v.re = re; v.we = we; v.sz = sz; v.sg = sg; v.addr = a; v.wdata = wd; v.delay = d;
      v.x_rdata = xr; v.x_err = xe; v.x_stall = xs; v.x_be = xbe; v.x_maddr = xma; v.x_mwdata = xwd;
      return v;
   endfunction

   vec_t tbl [17];
   obs_t o;
   exp_t e;

   initial begin
      for (int i = 0; i < 1024; i++) begin sram[i] = 32'd0; ref_mem[i] = 32'd0; end
      sram[2] = 32'h80FF7F01;

      // Reset state, with a request present to show stall is gated by reset.
      re_in = 1'b1; size_in = 2'b11; addr_in = 32'h40;
      #1;
      check("rst_stall", stall_out, 0);
      check("rst_req", mem_req_out, 0);
      check("rst_we", mem_we_out, 0);
      check("rst_be", mem_be_out, 0);
      check("rst_addr", mem_addr_out, 0);
      check("rst_wdata", mem_wdata_out, 0);
      check("rst_rdata", rdata_out, 0);
      check("rst_err", err_out, 0);
      @(negedge clk);
      re_in = 1'b0;
      reset_n = 1'b1;

      //          re we sz  sg addr      wdata        d   rdata        err stall be       maddr   mwdata
      tbl[0]  = mk(0, 1, 3, 0, 32'h40, 32'hDEADBEEF, 1, 32'h0,        0, 2,  4'b1111, 10'h10, 32'hDEADBEEF);
      tbl[1]  = mk(1, 0, 3, 0, 32'h40, 32'h0,        1, 32'hDEADBEEF, 0, 2,  4'b1111, 10'h10, 32'h0);
      tbl[2]  = mk(1, 0, 0, 1, 32'h0B, 32'h0,        1, 32'hFFFFFF80, 0, 2,  4'b1000, 10'h2,  32'h0);
      tbl[3]  = mk(1, 0, 0, 0, 32'h0B, 32'h0,        2, 32'h00000080, 0, 3,  4'b1000, 10'h2,  32'h0);
      tbl[4]  = mk(1, 0, 1, 1, 32'h0A, 32'h0,        1, 32'hFFFF80FF, 0, 2,  4'b1100, 10'h2,  32'h0);
      tbl[5]  = mk(1, 0, 1, 0, 32'h08, 32'h0,        3, 32'h00007F01, 0, 4,  4'b0011, 10'h2,  32'h0);
      tbl[6]  = mk(0, 1, 0, 0, 32'h05, 32'h000000A5, 1, 32'h0,        0, 2,  4'b0010, 10'h1,  32'hA5A5A5A5);
      tbl[7]  = mk(0, 1, 1, 0, 32'h06, 32'h00001234, 1, 32'h0,        0, 2,  4'b1100, 10'h1,  32'h12341234);
      tbl[8]  = mk(1, 0, 3, 0, 32'h04, 32'h0,        1, 32'h1234A500, 0, 2,  4'b1111, 10'h1,  32'h0);
      tbl[9]  = mk(1, 0, 3, 0, 32'h42, 32'h0,        1, 32'h0,        1, 1,  4'b0000, 10'h0,  32'h0);
      tbl[10] = mk(1, 1, 3, 0, 32'h40, 32'h0,        1, 32'h0,        1, 1,  4'b0000, 10'h0,  32'h0);
      tbl[11] = mk(1, 0, 2, 0, 32'h40, 32'h0,        1, 32'h0,        1, 1,  4'b0000, 10'h0,  32'h0);
      tbl[12] = mk(1, 0, 1, 1, 32'h09, 32'h0,        1, 32'h0,        1, 1,  4'b0000, 10'h0,  32'h0);
      tbl[13] = mk(1, 0, 3, 0, 32'h40, 32'h0,        0, 32'h0,        1, 16, 4'b1111, 10'h10, 32'h0);
      tbl[14] = mk(1, 0, 3, 0, 32'h40, 32'h0,       15, 32'hDEADBEEF, 0, 16, 4'b1111, 10'h10, 32'h0);
      tbl[15] = mk(1, 0, 0, 1, 32'h08, 32'h0,        1, 32'h00000001, 0, 2,  4'b0001, 10'h2,  32'h0);
      tbl[16] = mk(1, 0, 0, 1, 32'h1000040B, 32'h0,  1, 32'hFFFFFFEF, 0, 2,  4'b1000, 10'h102, 32'h0);
      sram[10'h102] = 32'hEF000000;

      for (int t = 0; t < 17; t++) begin
         run_access(tbl[t].re, tbl[t].we, tbl[t].sz, tbl[t].sg, tbl[t].addr, tbl[t].wdata, tbl[t].delay, o);
         $display("vec %0d re=%0d we=%0d size=%0d addr=0x%08h stall=%0d err=%0d rdata=0x%08h",
                  t, tbl[t].re, tbl[t].we, tbl[t].sz, tbl[t].addr, o.stall, o.err, o.rdata);
         check($sformatf("vec%0d_stall", t), o.stall, tbl[t].x_stall);
         check($sformatf("vec%0d_reqc", t), o.reqc, tbl[t].x_stall - 1);
         check($sformatf("vec%0d_err", t), o.err, tbl[t].x_err);
         check($sformatf("vec%0d_rdata", t), o.rdata, tbl[t].x_rdata);
         check($sformatf("vec%0d_req_after", t), o.req_after, 0);
         if (tbl[t].x_stall > 1) begin
            check($sformatf("vec%0d_be", t), o.be, tbl[t].x_be);
            check($sformatf("vec%0d_maddr", t), o.maddr, tbl[t].x_maddr);
            check($sformatf("vec%0d_mwe", t), o.mwe, tbl[t].we);
            if (tbl[t].we) check($sformatf("vec%0d_mwdata", t), o.mwdata, tbl[t].x_mwdata);
         end
      end

      // Reset asserted during the third REQ cycle abandons the access at once.
      re_in = 1'b1; we_in = 1'b0; size_in = 2'b11; signed_in = 1'b0; addr_in = 32'h40;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      #1;
      check("midreq_req_before", mem_req_out, 1);
      reset_n = 1'b0;
      #1;
      check("midreq_req", mem_req_out, 0);
      check("midreq_stall", stall_out, 0);
      check("midreq_addr", mem_addr_out, 0);
      re_in = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      check("midreq_idle_stall", stall_out, 0);
      run_access(1, 0, 2'b11, 0, 32'h40, 32'h0, 2, o);
      $display("post-reset lw addr=0x00000040 stall=%0d err=%0d rdata=0x%08h", o.stall, o.err, o.rdata);
      check("postrst_stall", o.stall, 3);
      check("postrst_err", o.err, 0);
      check("postrst_rdata", o.rdata, 32'hDEADBEEF);

      // Randomized transactions against the reference model.
      for (int i = 0; i < 1024; i++) begin sram[i] = $urandom; ref_mem[i] = sram[i]; end
      for (int t = 0; t < 60; t++) begin
         logic r_re, r_we, r_sg;
         logic [1:0] r_sz;
         logic [31:0] r_a, r_wd;
         int sel, r_d;
         sel = $urandom_range(0, 9);
         r_re = (sel == 0) || (sel <= 5);
         r_we = (sel == 0) || (sel > 5);
         sel = $urandom_range(0, 7);
         r_sz = (sel == 0) ? 2'b10 : (sel <= 3) ? 2'b00 : (sel <= 5) ? 2'b01 : 2'b11;
         r_sg = 1'($urandom_range(0, 1));
         r_a  = $urandom;
         if ($urandom_range(0, 3) != 0) begin
            if (r_sz == 2'b11) r_a[1:0] = 2'b00;
            else if (r_sz == 2'b01) r_a[0] = 1'b0;
         end
         r_wd = $urandom;
         sel = $urandom_range(0, 19);
         r_d = (sel == 0) ? 0 : (sel == 1) ? TIMEOUT : $urandom_range(1, 4);
         model(r_re, r_we, r_sz, r_sg, r_a, r_wd, r_d, e);
         run_access(r_re, r_we, r_sz, r_sg, r_a, r_wd, r_d, o);
         $display("rnd %0d re=%0d we=%0d size=%0d sg=%0d addr=0x%08h wdata=0x%08h d=%0d stall=%0d err=%0d rdata=0x%08h",
                  t, r_re, r_we, r_sz, r_sg, r_a, r_wd, r_d, o.stall, o.err, o.rdata);
         check($sformatf("rnd%0d_stall", t), o.stall, e.stall);
         check($sformatf("rnd%0d_err", t), o.err, e.err);
         check($sformatf("rnd%0d_rdata", t), o.rdata, e.rdata);
         check($sformatf("rnd%0d_req_after", t), o.req_after, 0);
         check($sformatf("rnd%0d_reqc", t), o.reqc, e.legal ? e.stall - 1 : 0);
         if (e.legal) begin
            check($sformatf("rnd%0d_be", t), o.be, e.be);
            check($sformatf("rnd%0d_maddr", t), o.maddr, e.maddr);
            check($sformatf("rnd%0d_mwe", t), o.mwe, r_we);
            if (r_we) check($sformatf("rnd%0d_mwdata", t), o.mwdata, e.mwdata);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
